// File: rtl/fetch_queue_pkg.sv
// Shared types and width helpers for the fetch queue.
// Optional feature macro: FETCH_QUEUE_STATS_EN (adds a stall_full_cycles counter).
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  localparam int FQ_FETCH_W = 2;
  localparam int FQ_DEPTH   = 8;
  localparam int FQ_PTR_W   = $clog2(FQ_DEPTH);
  localparam int FQ_CNT_W   = FQ_PTR_W + 1;

  // Pointer width: indexes DEPTH slots, wraps by natural overflow.
  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so a full queue (count == DEPTH) is representable.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of a per-cycle lane count (0..FETCH_W).
  function automatic int fq_lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_compact.sv
// Combinational lane compaction: squeezes the valid fetch lanes to the low
// output slots in program order and reports how many there are.
module fetch_queue_compact
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_W = FQ_FETCH_W
) (
  input  logic [FETCH_W-1:0]                        fetch_valid,
  input  logic [FETCH_W-1:0][31:0]                  fetch_instr,
  input  logic [FETCH_W-1:0][31:0]                  fetch_pc,
  output fq_entry_t [FETCH_W-1:0]                   entries,
  output logic [$clog2(FETCH_W+1)-1:0]              nenq
);

  localparam int NW = fq_lane_cnt_w(FETCH_W);

  logic [FETCH_W-1:0][NW-1:0] pos;

  // Exclusive prefix count of valid lanes gives each lane's destination slot.
  always_comb begin : prefix
    logic [NW-1:0] acc;
    acc = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      pos[i] = acc;
      acc    = acc + NW'(fetch_valid[i]);
    end
    nenq = acc;
  end

  for (genvar j = 0; j < FETCH_W; j++) begin : g_slot
    fq_entry_t slot;

    // Slot j takes the lane whose prefix count equals j; only lanes >= j can land here.
    always_comb begin
      slot = '0;
      for (int i = j; i < FETCH_W; i++) begin
        if (fetch_valid[i] && pos[i] == NW'(j)) begin
          slot.instr = fetch_instr[i];
          slot.pc    = fetch_pc[i];
        end
      end
    end

    assign entries[j] = slot;
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode.
// Accepts up to FETCH_W packed instructions per cycle, presents the oldest
// FETCH_W to decode, and drops everything on flush.
// Optional feature macro: FETCH_QUEUE_STATS_EN adds stall_full_cycles.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_W = FQ_FETCH_W,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [FETCH_W-1:0]         fetch_valid,
  input  logic [FETCH_W-1:0][31:0]   fetch_instr,
  input  logic [FETCH_W-1:0][31:0]   fetch_pc,
  output logic                       fetch_ready,
  output logic [FETCH_W-1:0]         instr_valid,
  output logic [FETCH_W-1:0][31:0]   instr,
  output logic [FETCH_W-1:0][31:0]   pc,
  input  logic                       decode_ready,
  output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                stall_full_cycles
`endif
);

  localparam int PTR_W = fq_ptr_w(DEPTH);
  localparam int CNT_W = fq_cnt_w(DEPTH);
  localparam int NW    = fq_lane_cnt_w(FETCH_W);

  fq_entry_t              mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;

  fq_entry_t [FETCH_W-1:0] comp;
  logic [NW-1:0]          nenq_raw;
  logic [NW-1:0]          nenq;
  logic [CNT_W-1:0]       ndeq;
  logic                   do_enq;
  logic                   do_deq;

  fetch_queue_compact #(.FETCH_W(FETCH_W)) u_compact (
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .entries     (comp),
    .nenq        (nenq_raw)
  );

  // Space for a whole group is judged on current occupancy only; a dequeue in
  // the same cycle does not open the gate, keeping fetch_ready off the decode path.
  assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
  assign do_enq      = fetch_ready && !flush;
  assign do_deq      = decode_ready && !flush;

  // Per-cycle enqueue/dequeue amounts; decode takes all presented lanes or none.
  always_comb begin
    nenq = do_enq ? nenq_raw : '0;
    ndeq = '0;
    if (do_deq) ndeq = (count >= CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : count;
  end

  // Pointer and occupancy update; flush wins over both enqueue and dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(ndeq);
      tail  <= tail + PTR_W'(nenq);
      count <= count + CNT_W'(nenq) - ndeq;
    end
  end

  // Storage write: compacted slot k lands at tail+k; contents are never cleared,
  // stale entries are hidden by instr_valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (NW'(k) < nenq) mem[tail + PTR_W'(k)] <= comp[k];
    end
  end

  for (genvar i = 0; i < FETCH_W; i++) begin : g_rd
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx         = head + PTR_W'(i);
    assign instr_valid[i] = count > CNT_W'(i);
    assign instr[i]       = instr_valid[i] ? mem[rd_idx].instr : '0;
    assign pc[i]          = instr_valid[i] ? mem[rd_idx].pc    : '0;
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Count cycles where fetch offered work but the queue had no room; saturating, survives flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_full_cycles <= '0;
    else if (|fetch_valid && !fetch_ready && stall_full_cycles != 32'hFFFF_FFFF)
      stall_full_cycles <= stall_full_cycles + 32'd1;
  end
`endif

endmodule
